// File: rtl/mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package mmio_pkg;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_t;

  localparam logic [1:0] TXDATA_OFF = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] CTRL_OFF   = 2'd2;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_OVF   = 3;
  localparam int unsigned STAT_COUNT = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART: core-side strobes plus the registered read return.
interface mmio_uart_tx_if #(
  parameter int unsigned N = 64
);
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] mmio_readData;
  logic         mmio_hit;

  modport master (
    output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    input  mmio_readData, mmio_hit
  );

  modport slave (
    input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
    output mmio_readData, mmio_hit
  );
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is dropped even when a pop lands the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// UART transmitter on the data-memory bus: register decode, TX FIFO, baud counter and 8N1 FSM.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned  N     = 64,
  parameter logic [N-1:0] BASE  = N'('h2000),
  parameter int unsigned  DIV   = 434,
  parameter int unsigned  DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             tx,
  output logic             irq
);

  localparam int unsigned      CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned      BaudW   = $clog2(DIV);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(DIV - 1);

  logic            sel, wr_sel, rd_sel, push;
  logic [1:0]      off;
  logic            fifo_pop, full, empty;
  logic [7:0]      fifo_dout;
  logic [CntW-1:0] count;
  logic [N-1:0]    status, rdata_d, rdata_q;
  logic            ovf_d, ovf_q, ie_d, ie_q, irq_q, hit_q;
  uart_state_t     state_d, state_q;
  logic [BaudW-1:0] baud_d, baud_q;
  logic [2:0]      bit_d, bit_q;
  logic [7:0]      shift_d, shift_q;
  logic            tx_d, tx_q;
  logic            unused_bits;

  assign sel    = (bus.DM_addr[N-1:5] == BASE[N-1:5]);
  assign off    = bus.DM_addr[4:3];
  assign wr_sel = sel & bus.DM_writeEnable;
  assign rd_sel = sel & bus.DM_readEnable;
  assign push   = wr_sel && (off == TXDATA_OFF);

  assign unused_bits = ^{bus.DM_writeData[N-1:8], bus.DM_addr[2:0]};

  sync_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .din   (bus.DM_writeData[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = (state_q != StIdle);
    status[STAT_FULL]           = full;
    status[STAT_EMPTY]          = empty;
    status[STAT_OVF]            = ovf_q;
    status[STAT_COUNT +: CntW]  = count;

    rdata_d = '0;
    if (rd_sel) begin
      unique case (off)
        STATUS_OFF: rdata_d    = status;
        CTRL_OFF:   rdata_d[0] = ie_q;
        default:    rdata_d    = '0;
      endcase
    end

    // Overflow set takes priority over a same-cycle clear.
    ovf_d = ovf_q;
    if (wr_sel && (off == STATUS_OFF)) ovf_d = 1'b0;
    if (push && full)                  ovf_d = 1'b1;

    ie_d = ie_q;
    if (wr_sel && (off == CTRL_OFF)) ie_d = bus.DM_writeData[0];
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = BaudMax;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) state_d = StIdle;
        else              baud_d  = baud_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the next state so tx never has a bus-to-pin path.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      ie_q    <= ie_d;
      irq_q   <= ie_q & empty;
      hit_q   <= rd_sel;
      rdata_q <= rdata_d;
    end
  end

  assign tx                = tx_q;
  assign irq               = irq_q;
  assign bus.mmio_hit      = hit_q;
  assign bus.mmio_readData = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with DIV=4: frames, FIFO overflow, status, interrupt, reset.
module tb_mmio_uart_tx;

  localparam int unsigned  N     = 64;
  localparam logic [N-1:0] BASE  = 64'h2000;
  localparam int unsigned  DIV   = 4;

  localparam logic [N-1:0] A_TXDATA = 64'h2000;
  localparam logic [N-1:0] A_STATUS = 64'h2008;
  localparam logic [N-1:0] A_CTRL   = 64'h2010;
  localparam logic [N-1:0] A_RSVD   = 64'h2018;

  logic clk, rst_n, tx, irq;
  int   n_checks, n_errors;

  mmio_uart_tx_if #(.N(N)) bus ();

  mmio_uart_tx #(
    .N     (N),
    .BASE  (BASE),
    .DIV   (DIV),
    .DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
    bus.DM_addr        = addr;
    bus.DM_writeData   = data;
    bus.DM_writeEnable = 1'b1;
    tick();
    bus.DM_writeEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [63:0] addr, output logic [63:0] data, output logic hit);
    bus.DM_addr       = addr;
    bus.DM_readEnable = 1'b1;
    tick();
    bus.DM_readEnable = 1'b0;
    data = bus.mmio_readData;
    hit  = bus.mmio_hit;
  endtask

  task automatic read_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    logic [63:0] d;
    logic        h;
    bus_read(addr, d, h);
    check_eq({tag, "_hit"}, {63'd0, h}, 64'd1);
    check_eq(tag, d, exp);
  endtask

  // Waits for the start bit, then compares all 10*DIV line samples against the 8N1 pattern.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    logic [39:0] got, exp;
    int          n, j;
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_start_seen"}, {63'd0, (n < 100)}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      j      = i / 4;
      exp[i] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
      got[i] = tx;
      if (i < 39) tick();
    end
    check_eq(tag, {24'd0, got}, {24'd0, exp});
    tick();
    check_eq({tag, "_idle"}, {63'd0, tx}, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic [63:0] d;
    logic        h;
    int          n;
    n = 0;
    d = '1;
    while (d != 64'h04 && n < 1500) begin
      bus_read(A_STATUS, d, h);
      n++;
    end
    check_eq(tag, d, 64'h04);
  endtask

  task automatic count_lows(input string tag, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check_eq(tag, 64'(lows), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    logic        h;
    n_checks           = 0;
    n_errors           = 0;
    rst_n              = 1'b0;
    bus.DM_addr        = '0;
    bus.DM_writeData   = '0;
    bus.DM_writeEnable = 1'b0;
    bus.DM_readEnable  = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", {63'd0, tx}, 64'd1);
    check_eq("rst_irq", {63'd0, irq}, 64'd0);
    check_eq("rst_hit", {63'd0, bus.mmio_hit}, 64'd0);
    check_eq("rst_rdata", bus.mmio_readData, 64'd0);
    #1 rst_n = 1'b1;
    tick();
    read_check("rst_status", A_STATUS, 64'h04);
    read_check("rst_ctrl", A_CTRL, 64'h0);
    read_check("txdata_read", A_TXDATA, 64'h0);
    bus_write(A_RSVD, 64'hFF);
    read_check("rsvd_read", A_RSVD, 64'h0);
    bus_read(64'h1008, d, h);
    check_eq("unsel_hit", {63'd0, h}, 64'd0);
    check_eq("unsel_data", d, 64'd0);
    bus_write(64'h1000, 64'h33);
    read_check("unsel_no_push", A_STATUS, 64'h04);

    // Single frame
    bus_write(A_TXDATA, 64'h55);
    check_eq("tx_before_pop", {63'd0, tx}, 64'd1);
    tick();
    check_eq("tx_fall_2edges", {63'd0, tx}, 64'd0);
    expect_frame("frame_55", 8'h55);
    read_check("status_after_frame", A_STATUS, 64'h04);

    // Fill and overflow: 'hFF has a single low level, so the next fall is the next start bit
    bus_write(A_TXDATA, 64'hFF);
    tick();
    for (int i = 0; i < 10; i++) bus_write(A_TXDATA, 64'(8'h20 + i));
    read_check("status_full_ovf", A_STATUS, 64'h8B);
    for (int i = 0; i < 8; i++) expect_frame($sformatf("ovf_frame%0d", i), 8'(8'h20 + i));
    count_lows("no_extra_frames", 60);
    read_check("status_ovf_sticky", A_STATUS, 64'h0C);

    // Overflow clear
    bus_write(A_STATUS, 64'h0);
    read_check("ovf_cleared", A_STATUS, 64'h04);
    bus_write(A_TXDATA, 64'hFF);
    tick();
    for (int i = 0; i < 8; i++) bus_write(A_TXDATA, 64'hFF);
    bus_write(A_STATUS, 64'h0);
    bus_write(A_TXDATA, 64'hFF);
    read_check("ovf_set_after_clear", A_STATUS, 64'h8B);
    bus_write(A_STATUS, 64'h0);
    read_check("ovf_clear_while_full", A_STATUS, 64'h83);
    wait_idle("drain_after_ovf");

    // Interrupt
    bus_write(A_CTRL, 64'h1);
    check_eq("irq_lags_ie", {63'd0, irq}, 64'd0);
    tick();
    check_eq("irq_set", {63'd0, irq}, 64'd1);
    read_check("ctrl_ie", A_CTRL, 64'h1);
    bus_write(A_TXDATA, 64'hA5);
    tick();
    check_eq("irq_after_push", {63'd0, irq}, 64'd0);
    tick();
    check_eq("irq_after_pop", {63'd0, irq}, 64'd1);
    wait_idle("drain_a5");
    bus_write(A_CTRL, 64'h0);
    tick();
    tick();
    check_eq("irq_ie_off", {63'd0, irq}, 64'd0);

    // Reset mid-frame during DATA bit 3 ('hF7 drives bit 3 low)
    bus_write(A_TXDATA, 64'hF7);
    tick();
    repeat (17) tick();
    check_eq("bit3_low", {63'd0, tx}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", {63'd0, tx}, 64'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    read_check("status_after_rst", A_STATUS, 64'h04);
    count_lows("no_residual_bits", 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
